ahb_input_port: RTL and testbench

AHB_INPUT_PORT -- requirements
Module: ahb_input_port

---
 rtl/ahb_input_port.sv | 144 ++++++++++++++
 tb/tb_ahb_input_port.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_input_port.sv
// AHB-Lite slave that synchronises and debounces 16 switches and 2 push-buttons,
// exposes them as read-only registers and raises a level IRQ on button presses.
module ahb_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [15:0] Switches,
  input  logic [1:0]  Buttons,
  output logic        IRQ
);

  localparam int unsigned NumIn  = 18;
  localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] AddrSw  = 2'd0;
  localparam logic [1:0] AddrBtn = 2'd1;
  localparam logic [1:0] AddrEvt = 2'd2;
  localparam logic [1:0] AddrIen = 2'd3;

  // Bits [15:0] are the switches, bits [17:16] the buttons.
  logic [NumIn-1:0]       raw;
  logic [NumIn-1:0]       sync1_q, sync2_q;
  logic [NumIn-1:0]       stable_q, stable_d;
  logic [NumIn-1:0][15:0] cnt_q, cnt_d;

  logic       trans_valid;
  logic       wr_q, rd_q;
  logic [1:0] addr_q;

  logic [1:0] evt_q, evt_d;
  logic [1:0] ien_q, ien_d;
  logic [1:0] evt_rise, evt_clr;
  logic       irq_q;

  // Only HADDR[3:2] is decoded, and all accesses are treated as full words.
  logic unused_bus;
  assign unused_bus = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:2]};

  assign raw = {Buttons, Switches};

  // Two-flop synchroniser on every asynchronous input.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debouncer: count consecutive disagreeing edges, adopt the new level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Debouncer state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign trans_valid = HSEL & HREADY & HTRANS[1];

  // Address phase capture; the data phase follows on the next cycle with no wait states.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      wr_q <= trans_valid & HWRITE;
      rd_q <= trans_valid & ~HWRITE;
      if (trans_valid) begin
        addr_q <= HADDR[3:2];
      end
    end
  end

  // Event flags and enables; a new button press wins over a simultaneous clear.
  always_comb begin
    evt_rise = stable_d[17:16] & ~stable_q[17:16];
    evt_clr  = (wr_q && addr_q == AddrEvt) ? HWDATA[1:0] : 2'b00;
    evt_d    = (evt_q & ~evt_clr) | evt_rise;
    ien_d    = (wr_q && addr_q == AddrIen) ? HWDATA[1:0] : ien_q;
  end

  // Register file and registered interrupt.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      evt_q <= '0;
      ien_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      ien_q <= ien_d;
      irq_q <= |(evt_q & ien_q);
    end
  end

  // Read data is driven only while a read is in its data phase.
  always_comb begin
    HRDATA = '0;
    if (rd_q) begin
      case (addr_q)
        AddrSw:  HRDATA = {16'h0000, stable_q[15:0]};
        AddrBtn: HRDATA = {30'h0, stable_q[17:16]};
        AddrEvt: HRDATA = {30'h0, evt_q};
        default: HRDATA = {30'h0, ien_q};
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = irq_q;

endmodule

// File: tb/tb_ahb_input_port.sv
// Bench for ahb_input_port: directed scenarios plus randomised switch/button activity,
// checked against a sliding-window behavioural model of the debounced inputs.
module tb_ahb_input_port;

  localparam int unsigned D = 16;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [15:0] Switches;
  logic [1:0]  Buttons;
  logic        IRQ;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit bad_resp = 1'b0;

  ahb_input_port #(.DEBOUNCE_CYCLES(D)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .Switches  (Switches),
    .Buttons   (Buttons),
    .IRQ       (IRQ)
  );

  always #5 HCLK = ~HCLK;

  // Reference model. The debounced level flips when the last D synchronised samples
  // (input seen two edges earlier) all disagree with it.
  logic [17:0] hist [0:D+1];
  logic [17:0] m_stab;
  logic [1:0]  m_evt, m_ien, m_wa;
  logic        m_irq, m_wr;

  function automatic logic [17:0] win_stable();
    logic [17:0] r;
    bit          flip;
    r = m_stab;
    for (int b = 0; b < 18; b++) begin
      flip = 1'b1;
      for (int j = 1; j <= D; j++) begin
        if (hist[j][b] == m_stab[b]) flip = 1'b0;
      end
      if (flip) r[b] = ~m_stab[b];
    end
    return r;
  endfunction

  function automatic logic [1:0] btn_rise();
    logic [17:0] n;
    n = win_stable();
    return n[17:16] & ~m_stab[17:16];
  endfunction

  function automatic logic [31:0] mreg(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_stab[15:0]};
      2'd1:    return {30'h0, m_stab[17:16]};
      2'd2:    return {30'h0, m_evt};
      default: return {30'h0, m_ien};
    endcase
  endfunction

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i <= D + 1; i++) hist[i] <= '0;
      m_stab <= '0;
      m_evt  <= '0;
      m_ien  <= '0;
      m_irq  <= 1'b0;
      m_wr   <= 1'b0;
      m_wa   <= '0;
    end else begin
      for (int i = 0; i < D + 1; i++) hist[i] <= hist[i+1];
      hist[D+1] <= {Buttons, Switches};
      m_stab    <= win_stable();
      m_evt     <= (m_evt & ~((m_wr && m_wa == 2'd2) ? HWDATA[1:0] : 2'b00)) | btn_rise();
      m_ien     <= (m_wr && m_wa == 2'd3) ? HWDATA[1:0] : m_ien;
      m_irq     <= |(m_evt & m_ien);
      m_wr      <= HSEL & HREADY & HTRANS[1] & HWRITE;
      m_wa      <= HADDR[3:2];
    end
  end

  always @(negedge HCLK) begin
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) bad_resp = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'($urandom);
    HADDR  = $urandom;
  endtask

  task automatic addr_ph(input logic [1:0] a, input logic w);
    HSEL       = 1'b1;
    HTRANS     = {1'b1, 1'($urandom)};
    HWRITE     = w;
    HADDR      = $urandom;
    HADDR[3:2] = a;
    HSIZE      = 3'($urandom);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data);
    addr_ph(a, 1'b1);
    @(negedge HCLK);
    idle();
    HWDATA = data;
    chk("hrdata_zero_in_write", HRDATA, 32'h0);
    @(negedge HCLK);
    HWDATA = $urandom;
  endtask

  task automatic rd(input logic [1:0] a, input string tag, output logic [31:0] data);
    addr_ph(a, 1'b0);
    @(negedge HCLK);
    idle();
    data = HRDATA;
    chk(tag, data, mreg(a));
  endtask

  initial begin
    logic [31:0] d;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    HSIZE = 3'b010; HREADY = 1'b1; HWDATA = '0; Switches = 16'h0001; Buttons = 2'b00;

    // Reset state.
    repeat (3) @(negedge HCLK);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_hreadyout", HREADYOUT, 32'h1);
    chk("rst_hresp", HRESP, 32'h0);
    chk("rst_irq", IRQ, 32'h0);

    // Switch held at 1 through reset: 0 at 10 clocks, 1 at 20 clocks.
    HRESET = 1'b0;
    repeat (9) @(negedge HCLK);
    rd(2'd0, "sw_at10", d);
    chk("sw_at10_const", d, 32'h0);
    repeat (9) @(negedge HCLK);
    rd(2'd0, "sw_at20", d);
    chk("sw_at20_const", d, 32'h1);
    rd(2'd2, "evt_not_set_by_sw", d);
    chk("evt_not_set_by_sw_const", d, 32'h0);

    // 0x0001 -> 0x000F lands exactly on the 18th edge.
    Switches = 16'h000F;
    repeat (16) @(negedge HCLK);
    rd(2'd0, "sw_edge17", d);
    chk("sw_edge17_const", d, 32'h1);
    rd(2'd0, "sw_edge18", d);
    chk("sw_edge18_const", d, 32'hF);

    // Short glitch never reaches the register.
    Switches = 16'hFFFF;
    repeat (5) @(negedge HCLK);
    Switches = 16'h000F;
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge HCLK);
      rd(2'd0, "glitch_model", d);
      chk("glitch_const", d, 32'hF);
    end

    // Randomised input activity, including partial-length pulses.
    for (int it = 0; it < 10; it++) begin
      Switches = 16'($urandom);
      Buttons  = 2'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, D - 1)) @(negedge HCLK);
        Switches = 16'($urandom);
        Buttons  = 2'($urandom);
      end
      repeat ($urandom_range(4, 2 * D + 4)) @(negedge HCLK);
      rd(2'd0, "rand_sw", d);
      rd(2'd1, "rand_btn", d);
      rd(2'd2, "rand_evt", d);
    end
    Buttons = 2'b00;
    repeat (2 * D + 4) @(negedge HCLK);
    wr(2'd2, 32'h3);
    rd(2'd2, "evt_cleared", d);
    chk("evt_cleared_const", d, 32'h0);

    // Button 0 press with IEN=01, then write-1-clear.
    wr(2'd3, 32'h1);
    Buttons = 2'b01;
    repeat (25) @(negedge HCLK);
    rd(2'd2, "evt_b0", d);
    chk("evt_b0_const", d, 32'h1);
    chk("irq_b0", IRQ, m_irq);
    chk("irq_b0_const", IRQ, 32'h1);
    wr(2'd2, 32'h1);
    chk("irq_lag_const", IRQ, 32'h1);
    @(negedge HCLK);
    chk("irq_clr", IRQ, m_irq);
    chk("irq_clr_const", IRQ, 32'h0);
    rd(2'd2, "evt_clr", d);
    chk("evt_clr_const", d, 32'h0);
    repeat (20) @(negedge HCLK);
    Buttons = 2'b00;
    repeat (25) @(negedge HCLK);
    rd(2'd2, "evt_no_fall", d);
    chk("evt_no_fall_const", d, 32'h0);
    rd(2'd1, "btn_released", d);
    chk("btn_released_const", d, 32'h0);

    // Button 1 with IRQ disabled, then enable.
    wr(2'd3, 32'h0);
    Buttons = 2'b10;
    repeat (30) @(negedge HCLK);
    Buttons = 2'b00;
    repeat (25) @(negedge HCLK);
    rd(2'd2, "evt_b1", d);
    chk("evt_b1_const", d, 32'h2);
    chk("irq_b1_masked", IRQ, 32'h0);
    wr(2'd3, 32'h2);
    chk("irq_ien_lag", IRQ, 32'h0);
    @(negedge HCLK);
    chk("irq_ien_on", IRQ, 32'h1);
    wr(2'd2, 32'h3);

    // Clear of EVT[0] on the very edge the press is recognised: set wins.
    Buttons = 2'b01;
    repeat (16) @(negedge HCLK);
    wr(2'd2, 32'h1);
    rd(2'd2, "evt_set_wins", d);
    chk("evt_set_wins_const", d, 32'h1);
    Buttons = 2'b00;
    repeat (2 * D + 4) @(negedge HCLK);
    wr(2'd2, 32'h3);

    // Back-to-back write then read of IEN.
    addr_ph(2'd3, 1'b1);
    @(negedge HCLK);
    addr_ph(2'd3, 1'b0);
    HWDATA = 32'h3;
    @(negedge HCLK);
    idle();
    HWDATA = $urandom;
    chk("b2b_ien", HRDATA, mreg(2'd3));
    chk("b2b_ien_const", HRDATA, 32'h3);

    // Writes to read-only registers are ignored.
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, "sw_ro", d);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, "btn_ro", d);
    chk("btn_ro_const", d, 32'h0);

    // BUSY transfer and deselected NONSEQ must not touch IEN.
    HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'hC;
    @(negedge HCLK);
    idle();
    HWDATA = 32'h0;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'hC;
    @(negedge HCLK);
    idle();
    HWDATA = 32'h0;
    @(negedge HCLK);
    rd(2'd3, "ien_untouched", d);
    chk("ien_untouched_const", d, 32'h3);

    // Reset asserted mid-transfer with inputs held high.
    Buttons  = 2'b01;
    Switches = 16'h00F0;
    repeat (2 * D + 4) @(negedge HCLK);
    chk("irq_before_rst", IRQ, 32'h1);
    addr_ph(2'd3, 1'b1);
    @(negedge HCLK);
    idle();
    HWDATA = 32'h0;
    #2 HRESET = 1'b1;
    #1;
    chk("rst_async_irq", IRQ, 32'h0);
    chk("rst_async_hrdata", HRDATA, 32'h0);
    chk("rst_async_hreadyout", HREADYOUT, 32'h1);
    @(negedge HCLK);
    HRESET = 1'b0;
    rd(2'd3, "ien_after_rst", d);
    chk("ien_after_rst_const", d, 32'h0);
    rd(2'd2, "evt_after_rst", d);
    chk("evt_after_rst_const", d, 32'h0);
    rd(2'd0, "sw_after_rst", d);
    chk("sw_after_rst_const", d, 32'h0);
    repeat (20) @(negedge HCLK);
    rd(2'd1, "btn_held_rst", d);
    chk("btn_held_rst_const", d, 32'h1);
    rd(2'd2, "evt_btn_held_rst", d);
    chk("evt_btn_held_rst_const", d, 32'h1);
    rd(2'd0, "sw_held_rst", d);
    chk("sw_held_rst_const", d, 32'h00F0);

    chk("resp_ready_throughout", {31'h0, bad_resp}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
